seg7_scan_driver: RTL and testbench

Time-multiplexed driver for the board's 4-digit common-anode seven-segment display. It holds a double-buffered frame of four hex digits, each with a blank flag and a decimal-point flag. It steps the active-low anodes one digit per refresh slot and drives the encoded active-low cathodes. It is the output-side counterpart of the keypad column scanner: it uses the same 1 ms slot cadence and a guard interval at the start of each slot. Mode logic in `binary_refinement` loads frames into it; the block connects directly to the `an` and `rish` pins.

---
 rtl/seg7_pkg.sv | 32 +++
 rtl/seg7_hex_encoder.sv | 34 +++
 rtl/seg7_scan_driver.sv | 100 ++++++++++
 tb/tb_seg7_scan_driver.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and frame type for the seven-segment scan driver.
// Optional dimming is compiled in with the SEG7_DIM_EN macro (see seg7_scan_driver).
package seg7_pkg;

    // Active-low gfedcba patterns
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] ANODE_OFF = 4'hF;

    typedef struct packed {
        logic [15:0] digits;
        logic [3:0]  blank;
        logic [3:0]  dp;
    } frame_t;

endpackage

// File: rtl/seg7_hex_encoder.sv
// Combinational hex nibble to active-low seven-segment lookup with blanking.
module seg7_hex_encoder
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (nibble)
                4'h0: seg = SEG_0;
                4'h1: seg = SEG_1;
                4'h2: seg = SEG_2;
                4'h3: seg = SEG_3;
                4'h4: seg = SEG_4;
                4'h5: seg = SEG_5;
                4'h6: seg = SEG_6;
                4'h7: seg = SEG_7;
                4'h8: seg = SEG_8;
                4'h9: seg = SEG_9;
                4'hA: seg = SEG_A;
                4'hB: seg = SEG_B;
                4'hC: seg = SEG_C;
                4'hD: seg = SEG_D;
                4'hE: seg = SEG_E;
                default: seg = SEG_F;
            endcase
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode display scanner with a double-buffered frame.
// Define SEG7_DIM_EN to shorten the on phase according to the dim input.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV  = 100_000,
    parameter int BLANK_CYCLES = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [15:0] load_digits,
    input  logic [3:0]  load_blank,
    input  logic [3:0]  load_dp,
    input  logic [2:0]  dim,
    output logic [3:0]  an,
    output logic [7:0]  rish,
    output logic        frame_done
);

    localparam int TW = $clog2(REFRESH_DIV);

    logic [TW-1:0] scan_timer;
    logic [1:0]    digit_sel;
    frame_t        active;
    frame_t        pending;
    frame_t        load_frame;
    logic          pend_full;
    logic          slot_wrap;
    logic          frame_end;
    logic          accept;
    logic          on_phase;
    logic [3:0]    cur_digit;
    logic          cur_blank;
    logic          cur_dp;
    logic [6:0]    cur_seg;

    assign load_frame = {load_digits, load_blank, load_dp};
    assign load_ready = !pend_full;
    assign accept     = load_valid && !pend_full;
    assign slot_wrap  = (scan_timer == TW'(REFRESH_DIV - 1));
    assign frame_end  = slot_wrap && (digit_sel == 2'd3);

`ifdef SEG7_DIM_EN
    localparam int EIGHTH = REFRESH_DIV / 8;
    logic [TW:0] dim_limit;
    assign dim_limit = (TW+1)'((int'(dim) + 1) * EIGHTH);
    assign on_phase  = (scan_timer >= TW'(BLANK_CYCLES)) && ({1'b0, scan_timer} < dim_limit);
`else
    logic unused_dim;
    assign unused_dim = ^dim;
    assign on_phase   = (scan_timer >= TW'(BLANK_CYCLES));
`endif

    assign cur_digit = active.digits[{digit_sel, 2'b00} +: 4];
    assign cur_blank = active.blank[digit_sel];
    assign cur_dp    = active.dp[digit_sel];

    seg7_hex_encoder u_enc (
        .nibble (cur_digit),
        .blank  (cur_blank),
        .seg    (cur_seg)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            scan_timer <= '0;
            digit_sel  <= '0;
            active     <= '{digits: 16'h0000, blank: 4'hF, dp: 4'h0};
            pend_full  <= 1'b0;
            an         <= ANODE_OFF;
            rish       <= 8'hFF;
            frame_done <= 1'b0;
        end else begin
            scan_timer <= slot_wrap ? '0 : scan_timer + 1'b1;
            if (slot_wrap)
                digit_sel <= digit_sel + 2'd1;
            frame_done <= frame_end;
            an         <= on_phase ? ~(4'b0001 << digit_sel) : ANODE_OFF;
            rish       <= on_phase ? {~cur_dp, cur_seg} : 8'hFF;
            // The active frame only ever changes on the digit3 wrap so nothing is shown half-updated
            if (frame_end && pend_full) begin
                active    <= pending;
                pend_full <= 1'b0;
            end else if (frame_end && accept) begin
                active <= load_frame;
            end else if (accept) begin
                pend_full <= 1'b1;
            end
        end
    end

    // Pending contents are meaningless while pend_full is low, so no reset is needed
    always_ff @(posedge clk) begin
        if (accept)
            pending <= load_frame;
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized bench for seg7_scan_driver with a cycle-count based reference model.
module tb_seg7_scan_driver;

    localparam int RD = 16;
    localparam int BC = 1;
    localparam int FR = 4 * RD;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [15:0] load_digits = '0;
    logic [3:0]  load_blank = '0;
    logic [3:0]  load_dp = '0;
    logic [2:0]  dim = 3'd7;
    logic [3:0]  an;
    logic [7:0]  rish;
    logic        frame_done;

    always #5 clk = ~clk;

    seg7_scan_driver #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
        .clk         (clk),
        .rst         (rst),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_digits (load_digits),
        .load_blank  (load_blank),
        .load_dp     (load_dp),
        .dim         (dim),
        .an          (an),
        .rish        (rish),
        .frame_done  (frame_done)
    );

    int tests = 0;
    int fails = 0;

    logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    // Model: c = number of clock edges since reset release
    int          c = 0;
    bit          started = 0;
    logic [15:0] m_dig, p_dig;
    logic [3:0]  m_blk, m_dp, p_blk, p_dp;
    bit          m_pend = 0;
    logic [3:0]  e_an = 4'hF;
    logic [7:0]  e_rish = 8'hFF;
    logic        e_fd = 1'b0;
    logic        e_ready = 1'b1;
    int          tmr, sel;
    bit          on, fend, acc;
    logic [3:0]  nib;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (c=%0d)", name, act, exp, c);
        end
    endtask

    initial forever begin
        @(posedge clk);
        started = 1;
        if (!rst) begin
            c = 0;
            m_dig = '0; m_blk = 4'hF; m_dp = '0;
            m_pend = 0;
            e_an = 4'hF; e_rish = 8'hFF; e_fd = 1'b0;
        end else begin
            tmr = c % RD;
            sel = (c / RD) % 4;
            on  = (tmr >= BC);
`ifdef SEG7_DIM_EN
            on  = on && (tmr < (int'(dim) + 1) * (RD / 8));
`endif
            nib    = m_dig[4*sel +: 4];
            e_an   = on ? ~(4'b0001 << sel) : 4'hF;
            e_rish = on ? {~m_dp[sel], (m_blk[sel] ? 7'h7F : seg_tab[nib])} : 8'hFF;
            fend   = ((c % FR) == FR - 1);
            e_fd   = fend;
            acc    = load_valid && !m_pend;
            if (fend && m_pend) begin
                m_dig = p_dig; m_blk = p_blk; m_dp = p_dp;
                m_pend = 0;
            end else if (fend && acc) begin
                m_dig = load_digits; m_blk = load_blank; m_dp = load_dp;
            end else if (acc) begin
                p_dig = load_digits; p_blk = load_blank; p_dp = load_dp;
                m_pend = 1;
            end
            c++;
        end
        e_ready = !m_pend;
    end

    initial forever begin
        @(negedge clk);
        if (started) begin
            check("an", {4'h0, an}, {4'h0, e_an});
            check("rish", rish, e_rish);
            check("frame_done", {7'h0, frame_done}, {7'h0, e_fd});
            check("load_ready", {7'h0, load_ready}, {7'h0, e_ready});
        end
    end

    task automatic wait_c(input int k);
        while (c < k) @(negedge clk);
    endtask

    task automatic offer(input logic [15:0] d, input logic [3:0] b, input logic [3:0] p);
        load_valid = 1'b1; load_digits = d; load_blank = b; load_dp = p;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_an", {4'h0, an}, 8'h0F);
        check("rst_rish", rish, 8'hFF);
        check("rst_ready", {7'h0, load_ready}, 8'h01);
        check("rst_fd", {7'h0, frame_done}, 8'h00);
        rst = 1'b1;

        wait_c(3);   check("idle_an0", {4'h0, an}, 8'h0E); check("idle_rish", rish, 8'hFF);
        wait_c(19);  check("idle_an1", {4'h0, an}, 8'h0D);
        wait_c(35);  check("idle_an2", {4'h0, an}, 8'h0B);
        wait_c(51);  check("idle_an3", {4'h0, an}, 8'h07);

        wait_c(70);  offer(16'h1A2F, 4'h0, 4'b0001);
        wait_c(71);  load_valid = 1'b0;
        wait_c(72);  check("ready_drop", {7'h0, load_ready}, 8'h00);
        wait_c(127); check("fd_before", {7'h0, frame_done}, 8'h00);
        wait_c(128); check("fd_pulse", {7'h0, frame_done}, 8'h01);
        wait_c(131); check("d0_F_dp", rish, 8'h0E);
        wait_c(147); check("d1_2", rish, 8'hA4);
        wait_c(192); check("fd_pulse2", {7'h0, frame_done}, 8'h01);

        wait_c(200); offer(16'h0123, 4'h0, 4'h0);
        wait_c(201); load_digits = 16'h4567;
        wait_c(250); check("bp_held", {7'h0, load_ready}, 8'h00);
        wait_c(256); check("bp_ready", {7'h0, load_ready}, 8'h01);
        wait_c(257); load_valid = 1'b0; check("bp_second", {7'h0, load_ready}, 8'h00);
        wait_c(259); check("bp_first_shown", rish, 8'hB0);
        wait_c(323); check("bp_second_shown", rish, 8'hF8);

        wait_c(383); offer(16'h89AB, 4'h0, 4'h0);
        wait_c(384); load_valid = 1'b0; check("fe_ready", {7'h0, load_ready}, 8'h01);
        wait_c(387); check("fe_shown", rish, 8'h83);

        wait_c(400); offer(16'hFFFF, 4'b0100, 4'b0100);
        wait_c(401); load_valid = 1'b0;
        wait_c(449); check("guard0", {4'h0, an}, 8'h0F);
        wait_c(465); check("guard1", {4'h0, an}, 8'h0F);
        wait_c(483); check("blank_dp", rish, 8'h7F); check("blank_an", {4'h0, an}, 8'h0B);

`ifdef SEG7_DIM_EN
        wait_c(500); dim = 3'd1;
        wait_c(516); check("dim_on", {4'h0, an}, 8'h0E);
        wait_c(517); check("dim_off", {4'h0, an}, 8'h0F);
        wait_c(520); dim = 3'd7;
`endif

        wait_c(530);
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            load_valid  = ($urandom_range(0, 2) == 0);
            load_digits = 16'($urandom);
            load_blank  = 4'($urandom);
            load_dp     = 4'($urandom);
            dim         = 3'($urandom);
        end
        load_valid = 1'b0;
        dim = 3'd7;

        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_an", {4'h0, an}, 8'h0F);
        check("mid_rst_rish", rish, 8'hFF);
        check("mid_rst_ready", {7'h0, load_ready}, 8'h01);
        rst = 1'b1;
        wait_c(3);   check("restart_an0", {4'h0, an}, 8'h0E); check("restart_rish", rish, 8'hFF);
        wait_c(19);  check("restart_an1", {4'h0, an}, 8'h0D);
        wait_c(64);  check("restart_fd", {7'h0, frame_done}, 8'h01);
        wait_c(100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
